// File: rtl/cmd_ctrl_arbiter_if.sv
// ----------------------------------------------------------------------------
// cmd_ctrl_arbiter_if
//   Bundles the requester-side handshake and the single data-mover command
//   port (CMD_CTRL_*) that cmd_ctrl_arbiter multiplexes.
//
//   master : the environment. This is the requesters plus the data mover.
//            It drives req_valid, the packed request fields, CMD_CTRL_READY
//            and the completion pulses.
//   slave  : the arbiter. It drives req_ready, req_done, req_err and the
//            latched CMD_CTRL_* command.
//
//   Packed per-requester buses use 32-bit slices, slice i = [32i+31:32i].
// ----------------------------------------------------------------------------
interface cmd_ctrl_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    // Requester side
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_src_addr;
    logic [NUM_REQ*32-1:0] req_dst_addr;
    logic [NUM_REQ*32-1:0] req_btt;
    logic [NUM_REQ-1:0]    req_is_read;
    logic [NUM_REQ-1:0]    req_done;
    logic                  req_err;

    // Data-mover command port
    logic                  CMD_CTRL_READY;
    logic                  CMD_CTRL_START;
    logic [31:0]           CMD_CTRL_SRC_ADDR;
    logic [31:0]           CMD_CTRL_DST_ADDR;
    logic [31:0]           CMD_CTRL_BTT;
    logic                  CMD_CTRL_IS_READ;
    logic                  READ_COMPLETE;
    logic                  WRITE_COMPLETE;

    modport master (
        output req_valid, req_src_addr, req_dst_addr, req_btt, req_is_read,
        input  req_ready, req_done, req_err,
        output CMD_CTRL_READY, READ_COMPLETE, WRITE_COMPLETE,
        input  CMD_CTRL_START, CMD_CTRL_SRC_ADDR, CMD_CTRL_DST_ADDR,
               CMD_CTRL_BTT, CMD_CTRL_IS_READ
    );

    modport slave (
        input  req_valid, req_src_addr, req_dst_addr, req_btt, req_is_read,
        output req_ready, req_done, req_err,
        input  CMD_CTRL_READY, READ_COMPLETE, WRITE_COMPLETE,
        output CMD_CTRL_START, CMD_CTRL_SRC_ADDR, CMD_CTRL_DST_ADDR,
               CMD_CTRL_BTT, CMD_CTRL_IS_READ
    );
endinterface

// File: rtl/cmd_ctrl_arbiter.sv
// ----------------------------------------------------------------------------
// cmd_ctrl_arbiter
//   Shares one data-mover command port between NUM_REQ requesters.
//   Arbitration is round-robin, and only one command is outstanding at a time.
//   The grant is held until the matching READ_COMPLETE/WRITE_COMPLETE arrives
//   or the watchdog expires. At that point the owner gets a one-cycle req_done
//   pulse, and req_err marks a timeout.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   bus        cmd_ctrl_arbiter_if.slave, carrying the requester handshake
//              and the CMD_CTRL_* port
//   busy       high whenever a command is being issued or awaited
//   grant_idx  index of the current, or most recently granted, requester
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   IDX_W           clog2(NUM_REQ)
//   TIMEOUT_CYCLES  max cycles spent waiting for completion; 0 disables it
// ----------------------------------------------------------------------------
module cmd_ctrl_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned IDX_W          = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    cmd_ctrl_arbiter_if.slave  bus,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_idx
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam logic        WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0
                                                               : 32'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  timer;

    logic             arb_found;
    logic [IDX_W-1:0] arb_winner;
    logic             cmp_match;
    logic             timeout_hit;
    logic             grant_fire;
    logic             start_fire;
    logic             done_fire;
    logic             timeout_fire;

    // Unpack the request buses so the winner's fields are a plain array read.
    logic [31:0] src_slice [NUM_REQ];
    logic [31:0] dst_slice [NUM_REQ];
    logic [31:0] btt_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src_slice[g] = bus.req_src_addr[32*g +: 32];
        assign dst_slice[g] = bus.req_dst_addr[32*g +: 32];
        assign btt_slice[g] = bus.req_btt[32*g +: 32];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Round-robin search. Start just after the last grant and wrap, so
    // the previous owner has the lowest priority.
    // ------------------------------------------------------------------
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every variable gets a default before any conditional
        // assignment; otherwise synthesis infers a latch to hold it.
        arb_found  = 1'b0;
        arb_winner = grant_idx;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = int'(grant_idx) + i;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            cand_idx = IDX_W'(cand);
            if (!arb_found && bus.req_valid[cand_idx]) begin
                arb_found  = 1'b1;
                arb_winner = cand_idx;
            end
        end
    end

    // Only the completion that matches the latched direction counts.
    // The other pulse is ignored, even when both arrive together.
    assign cmp_match   = bus.CMD_CTRL_IS_READ ? bus.READ_COMPLETE : bus.WRITE_COMPLETE;
    assign timeout_hit = WDOG_EN && (timer == TIMER_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state is written with non-blocking assignments. All
    // registers then update together at the edge, whatever order the
    // processes are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (arb_found)                  state_nxt = S_ISSUE;
            S_ISSUE:     if (bus.CMD_CTRL_READY)         state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (cmp_match || timeout_hit)   state_nxt = S_IDLE;
            default:                                     state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (event strobes that feed the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        grant_fire   = 1'b0;
        start_fire   = 1'b0;
        done_fire    = 1'b0;
        timeout_fire = 1'b0;
        unique case (state)
            S_IDLE:      grant_fire = arb_found;
            S_ISSUE:     start_fire = bus.CMD_CTRL_READY;
            S_WAIT_DONE: begin
                // A completion on the final watchdog cycle still wins.
                done_fire    = cmp_match;
                timeout_fire = !cmp_match && timeout_hit;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Registered outputs, command latch and watchdog timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req_ready         <= '0;
            bus.req_done          <= '0;
            bus.req_err           <= 1'b0;
            bus.CMD_CTRL_START    <= 1'b0;
            bus.CMD_CTRL_SRC_ADDR <= '0;
            bus.CMD_CTRL_DST_ADDR <= '0;
            bus.CMD_CTRL_BTT      <= '0;
            bus.CMD_CTRL_IS_READ  <= 1'b1;
            grant_idx             <= LAST_IDX;   // requester 0 wins first
            timer                 <= '0;
        end else begin
            bus.req_ready      <= grant_fire ? onehot(arb_winner) : '0;
            bus.CMD_CTRL_START <= start_fire;
            bus.req_done       <= (done_fire || timeout_fire) ? onehot(grant_idx) : '0;
            bus.req_err        <= timeout_fire;

            // The command fields change only on a grant. Between commands
            // they hold the last command.
            if (grant_fire) begin
                grant_idx             <= arb_winner;
                bus.CMD_CTRL_SRC_ADDR <= src_slice[arb_winner];
                bus.CMD_CTRL_DST_ADDR <= dst_slice[arb_winner];
                bus.CMD_CTRL_BTT      <= btt_slice[arb_winner];
                bus.CMD_CTRL_IS_READ  <= bus.req_is_read[arb_winner];
            end

            // The timer runs only while awaiting completion, and it
            // saturates rather than wrapping.
            if (start_fire) begin
                timer <= '0;
            end else if (state == S_WAIT_DONE && timer != '1) begin
                timer <= timer + 32'd1;
            end
        end
    end

endmodule
